// File: rtl/rs422_pattern_gen_if.sv
// Byte strobe/acknowledge link between the pattern generator and the RS422 UART.
// A byte moves on any clock edge where data_out_stb and data_out_ack are both high.
interface rs422_pattern_gen_if;
  logic [7:0] data_out;
  logic       data_out_stb;
  logic       data_out_ack;

  modport master (output data_out, output data_out_stb, input data_out_ack);
  modport slave  (input data_out, input data_out_stb, output data_out_ack);
endinterface

// File: rtl/rs422_pattern_gen.sv
// Fixed / incrementing / PRBS-8 byte source for the RS422 test transmitter.
// It stops after a programmed byte count and reports progress to the OPB registers.
module rs422_pattern_gen #(
  parameter int GAP_CYCLES = 0
) (
  input  logic                  i_opb_clk,
  input  logic                  i_opb_rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_clear,
  input  logic [1:0]            i_mode,
  input  logic [7:0]            i_pattern,
  input  logic [31:0]           i_byte_count,
  rs422_pattern_gen_if.master   io_data,
  output logic [31:0]           o_sent_bytes,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_FINISH} state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [31:0]   r_count;
  logic [7:0]    r_data;
  logic          r_stb;
  logic [31:0]   r_sent;
  logic          r_busy;
  logic          r_done;
  logic [GW-1:0] r_gap;

  logic          w_xfer;
  logic [31:0]   w_sent_inc;
  logic [7:0]    w_first;
  logic          w_last;

  // x^8+x^6+x^5+x^4+1 LFSR; mode 11 falls through to fixed.
  function automatic logic [7:0] f_next_byte(input logic [1:0] mode, input logic [7:0] cur);
    case (mode)
      2'b01:   f_next_byte = cur + 8'd1;
      2'b10:   f_next_byte = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
      default: f_next_byte = cur;
    endcase
  endfunction

  assign w_xfer     = r_stb & io_data.data_out_ack;
  assign w_sent_inc = r_sent + 32'd1;
  // An all-zero seed would lock the LFSR, so PRBS starts from 0x01 instead.
  assign w_first    = (i_mode == 2'b10 && i_pattern == 8'h00) ? 8'h01 : i_pattern;
  assign w_last     = (r_count != 32'd0) && (w_sent_inc == r_count);

  always_ff @(posedge i_opb_clk or posedge i_opb_rst) begin
    if (i_opb_rst) begin
      r_state <= S_IDLE;
      r_mode  <= 2'b00;
      r_count <= 32'd0;
      r_data  <= 8'h00;
      r_stb   <= 1'b0;
      r_sent  <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gap   <= '0;
    end else if (i_clear) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_busy  <= 1'b0;
      r_sent  <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_count <= i_byte_count;
            r_data  <= w_first;
            r_stb   <= 1'b1;
            r_busy  <= 1'b1;
            r_sent  <= 32'd0;
            r_done  <= 1'b0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_sent <= w_sent_inc;
            r_data <= f_next_byte(r_mode, r_data);
          end
          // A byte accepted on the same edge as STOP still counts.
          if (i_stop) begin
            r_state <= S_IDLE;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_xfer) begin
            if (w_last) begin
              r_state <= S_FINISH;
              r_stb   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_stb   <= 1'b0;
              r_gap   <= GW'(GAP_CYCLES - 1);
            end
          end
        end
        S_GAP: begin
          if (i_stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_gap == '0) begin
            r_state <= S_SEND;
            r_stb   <= 1'b1;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_data.data_out     = r_data;
  assign io_data.data_out_stb = r_stb;
  assign o_sent_bytes         = r_sent;
  assign o_busy               = r_busy;
  assign o_done               = r_done;

endmodule

// File: tb/tb_rs422_pattern_gen.sv
// Bench for rs422_pattern_gen: a back-to-back (GAP 0) and a gapped (GAP 2) instance
// share stimulus and are both tracked by a byte-index reference model.
module tb_rs422_pattern_gen;

  logic        clk = 1'b0;
  logic        rst, start, stop, clear, ack;
  logic [1:0]  mode;
  logic [7:0]  pattern;
  logic [31:0] byte_count;
  logic [31:0] sent0, sent1;
  logic        busy0, busy1, done0, done1;

  always #5 clk = ~clk;

  rs422_pattern_gen_if bus0 ();
  rs422_pattern_gen_if bus1 ();
  assign bus0.data_out_ack = ack;
  assign bus1.data_out_ack = ack;

  rs422_pattern_gen #(.GAP_CYCLES(0)) dut0 (
    .i_opb_clk(clk), .i_opb_rst(rst), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_mode(mode), .i_pattern(pattern), .i_byte_count(byte_count), .io_data(bus0),
    .o_sent_bytes(sent0), .o_busy(busy0), .o_done(done0));

  rs422_pattern_gen #(.GAP_CYCLES(2)) dut1 (
    .i_opb_clk(clk), .i_opb_rst(rst), .i_start(start), .i_stop(stop), .i_clear(clear),
    .i_mode(mode), .i_pattern(pattern), .i_byte_count(byte_count), .io_data(bus1),
    .o_sent_bytes(sent1), .o_busy(busy1), .o_done(done1));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: progress is tracked as "index of the byte on offer" plus flags.
  logic [7:0]  prbs_tab [255];
  bit          m_run  [2];
  bit          m_stb  [2];
  bit          m_done [2];
  logic [31:0] m_sent [2];
  int          m_gap  [2];
  int          m_k    [2];
  logic [1:0]  m_mode [2];
  logic [7:0]  m_pat  [2];
  logic [31:0] m_cnt  [2];

  function automatic int gap_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic logic [7:0] exp_byte(int i);
    logic [7:0] seed;
    int idx;
    case (m_mode[i])
      2'b01: return m_pat[i] + 8'(m_k[i]);
      2'b10: begin
        seed = (m_pat[i] == 8'h00) ? 8'h01 : m_pat[i];
        idx = 0;
        for (int j = 0; j < 255; j++) if (prbs_tab[j] == seed) idx = j;
        return prbs_tab[(idx + m_k[i]) % 255];
      end
      default: return m_pat[i];
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit xfer;
      xfer = m_stb[i] && ack;
      if (rst) begin
        m_run[i] = 0; m_stb[i] = 0; m_done[i] = 0; m_sent[i] = 0; m_gap[i] = 0;
      end else if (clear) begin
        m_run[i] = 0; m_stb[i] = 0; m_done[i] = 0; m_sent[i] = 0;
      end else if (!m_run[i]) begin
        if (start) begin
          m_mode[i] = mode; m_pat[i] = pattern; m_cnt[i] = byte_count;
          m_k[i] = 0; m_sent[i] = 0; m_done[i] = 0; m_run[i] = 1; m_stb[i] = 1;
        end
      end else begin
        if (xfer) begin
          m_sent[i] = m_sent[i] + 32'd1;
          m_k[i]++;
        end
        if (stop) begin
          m_run[i] = 0; m_stb[i] = 0;
        end else if (xfer) begin
          if (m_cnt[i] != 0 && m_sent[i] == m_cnt[i]) begin
            m_run[i] = 0; m_stb[i] = 0; m_done[i] = 1;
          end else if (gap_of(i) > 0) begin
            m_stb[i] = 0; m_gap[i] = gap_of(i);
          end
        end else if (!m_stb[i]) begin
          m_gap[i]--;
          if (m_gap[i] == 0) m_stb[i] = 1;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      logic        o_stb, o_busy, o_done;
      logic [7:0]  o_data;
      logic [31:0] o_sent;
      o_stb  = (i == 0) ? bus0.data_out_stb : bus1.data_out_stb;
      o_data = (i == 0) ? bus0.data_out     : bus1.data_out;
      o_busy = (i == 0) ? busy0 : busy1;
      o_done = (i == 0) ? done0 : done1;
      o_sent = (i == 0) ? sent0 : sent1;
      check($sformatf("stb%0d", i),  {31'd0, o_stb},  {31'd0, m_stb[i]});
      check($sformatf("busy%0d", i), {31'd0, o_busy}, {31'd0, m_run[i]});
      check($sformatf("done%0d", i), {31'd0, o_done}, {31'd0, m_done[i]});
      check($sformatf("sent%0d", i), o_sent, m_sent[i]);
      if (m_stb[i]) check($sformatf("data%0d", i), {24'd0, o_data}, {24'd0, exp_byte(i)});
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle_ticks(int n);
    start = 0; stop = 0; clear = 0;
    for (int j = 0; j < n; j++) tick();
  endtask

  task automatic run_seq(input string tag, input logic [1:0] md, input logic [7:0] pat,
                         input logic [7:0] exp [6], input int n);
    mode = md; pattern = pat; byte_count = 32'(n); ack = 1; start = 1;
    tick();
    start = 0;
    for (int j = 0; j < n; j++) begin
      check({tag, "_byte"}, {24'd0, bus0.data_out}, {24'd0, exp[j]});
      check({tag, "_stb"}, {31'd0, bus0.data_out_stb}, 32'd1);
      tick();
    end
    check({tag, "_sent"}, sent0, 32'(n));
    check({tag, "_done"}, {31'd0, done0}, 32'd1);
    check({tag, "_stbend"}, {31'd0, bus0.data_out_stb}, 32'd0);
    idle_ticks(14);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] seq_fix [6];
    logic [7:0] seq_inc [6];
    logic [7:0] seq_prbs [6];
    v = 8'h01;
    for (int j = 0; j < 255; j++) begin
      prbs_tab[j] = v;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    seq_fix  = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h00, 8'h00};
    seq_inc  = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
    seq_prbs = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_stb[i] = 0; m_done[i] = 0; m_sent[i] = 0; m_gap[i] = 0;
      m_k[i] = 0; m_mode[i] = 0; m_pat[i] = 0; m_cnt[i] = 0;
    end

    rst = 1; start = 0; stop = 0; clear = 0; ack = 0;
    mode = 0; pattern = 0; byte_count = 0;
    @(negedge clk); @(negedge clk);
    check("rst_data0", {24'd0, bus0.data_out}, 32'd0);
    check("rst_data1", {24'd0, bus1.data_out}, 32'd0);
    compare();
    rst = 0;
    idle_ticks(2);

    run_seq("fixed", 2'b00, 8'h5A, seq_fix, 4);
    run_seq("incwrap", 2'b01, 8'hFE, seq_inc, 3);
    run_seq("prbs1", 2'b10, 8'h01, seq_prbs, 6);
    run_seq("prbs0", 2'b10, 8'h00, seq_prbs, 6);

    // Continuous PRBS: the 256th byte repeats the seed.
    mode = 2'b10; pattern = 8'h01; byte_count = 0; ack = 1; start = 1;
    tick();
    start = 0;
    for (int j = 0; j < 255; j++) tick();
    check("prbs_period", {24'd0, bus0.data_out}, 32'h01);
    check("cont_sent", sent0, 32'd255);
    stop = 1;
    tick();
    stop = 0;
    check("cont_done", {31'd0, done0}, 32'd0);
    idle_ticks(4);

    // Backpressure then gap on the GAP=2 instance.
    mode = 2'b01; pattern = 8'h10; byte_count = 3; ack = 0; start = 1;
    tick();
    start = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      check("bp_data", {24'd0, bus1.data_out}, 32'h10);
      check("bp_stb", {31'd0, bus1.data_out_stb}, 32'd1);
    end
    ack = 1;
    tick();
    check("gap_low1", {31'd0, bus1.data_out_stb}, 32'd0);
    tick();
    check("gap_low2", {31'd0, bus1.data_out_stb}, 32'd0);
    tick();
    check("gap_high", {31'd0, bus1.data_out_stb}, 32'd1);
    check("gap_data", {24'd0, bus1.data_out}, 32'h11);
    idle_ticks(10);

    // STOP together with the third accepted byte.
    mode = 2'b00; pattern = 8'h3C; byte_count = 10; ack = 1; start = 1;
    tick();
    start = 0;
    tick(); tick();
    stop = 1;
    tick();
    stop = 0;
    check("stop_sent", sent0, 32'd3);
    check("stop_busy", {31'd0, busy0}, 32'd0);
    check("stop_done", {31'd0, done0}, 32'd0);
    start = 1;
    tick();
    start = 0;
    check("restart_sent", sent0, 32'd0);
    check("restart_busy", {31'd0, busy0}, 32'd1);
    // START while busy must not recapture the pattern.
    pattern = 8'h77; start = 1;
    tick();
    start = 0;
    check("busy_start", {24'd0, bus0.data_out}, 32'h3C);
    clear = 1; start = 1;
    tick();
    clear = 0; start = 0;
    check("clr_busy", {31'd0, busy0}, 32'd0);
    check("clr_sent", sent0, 32'd0);
    check("clr_stb", {31'd0, bus0.data_out_stb}, 32'd0);
    idle_ticks(2);

    // Asynchronous reset mid-run.
    mode = 2'b01; pattern = 8'h40; byte_count = 0; start = 1;
    tick();
    start = 0;
    tick(); tick();
    #1 rst = 1;
    #1;
    check("arst_stb0", {31'd0, bus0.data_out_stb}, 32'd0);
    check("arst_data0", {24'd0, bus0.data_out}, 32'd0);
    check("arst_sent0", sent0, 32'd0);
    check("arst_busy0", {31'd0, busy0}, 32'd0);
    check("arst_stb1", {31'd0, bus1.data_out_stb}, 32'd0);
    check("arst_sent1", sent1, 32'd0);
    tick();
    rst = 0;
    idle_ticks(2);

    for (int n = 0; n < 3000; n++) begin
      start      = ($urandom % 12) == 0;
      stop       = ($urandom % 40) == 0;
      clear      = ($urandom % 90) == 0;
      rst        = ($urandom % 500) == 0;
      ack        = ($urandom % 10) < 7;
      mode       = 2'($urandom);
      pattern    = 8'($urandom);
      byte_count = (($urandom % 4) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      tick();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rs422_pattern_gen.md
# rs422_pattern_gen

Byte-stream pattern generator that sits directly upstream of the RS422 test transmitter UART. It produces a fixed, incrementing or PRBS-8 byte sequence over a strobe/acknowledge handshake and stops after a programmed byte count. It reports progress through a sent-byte counter and BUSY/DONE flags for the OPB register file.

## Interface
- GAP_CYCLES, default 0: idle cycles with STB low inserted after each accepted byte (0 = back-to-back).
- OPB_CLK  in  1  system clock; all logic on the rising edge.
- OPB_RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle start pulse.
- STOP  in  1  single-cycle stop pulse.
- CLEAR  in  1  single-cycle clear pulse; highest priority.
- MODE  in  2  00 fixed, 01 incrementing, 10 PRBS-8, 11 reserved (behaves as 00).
- PATTERN  in  8  fixed byte, increment start value, or PRBS seed.
- BYTE_COUNT  in  32  bytes to send; 0 = continuous.
- DATA_OUT  out  8  current byte; stable while DATA_OUT_STB=1.
- DATA_OUT_STB  out  1  byte valid.
- DATA_OUT_ACK  in  1  consumer accepts; transfer = STB & ACK in the same cycle.
- SENT_BYTES  out  32  accepted-byte count.
- BUSY  out  1  high in SEND or GAP.
- DONE  out  1  sticky; set when BYTE_COUNT bytes are sent.

## Operation
- States: IDLE, SEND, GAP, FINISH.
- START is accepted only in IDLE or FINISH, and only when CLEAR=0.
  - Captures MODE, PATTERN and BYTE_COUNT into shadow registers. Later input changes have no effect until the next START.
  - Clears SENT_BYTES and DONE, then enters SEND.
- START in SEND or GAP is ignored.
- First byte is PATTERN in all modes. PRBS exception: seed 0x00 is replaced by 0x01.
- Next byte after each transfer:
  - Fixed: unchanged.
  - Incrementing: +1 modulo 256 (0xFF -> 0x00).
  - PRBS-8: next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]} (x^8+x^6+x^5+x^4+1, period 255).
- On each transfer, SENT_BYTES increments by 1.
  - If BYTE_COUNT != 0 and the new value equals BYTE_COUNT: go to FINISH, drop STB, set DONE.
  - Otherwise go to GAP if GAP_CYCLES > 0, else stay in SEND with the next byte.
- GAP: STB low for exactly GAP_CYCLES cycles, then return to SEND.
- Continuous mode (BYTE_COUNT=0): SENT_BYTES wraps 0xFFFFFFFF -> 0. DONE never sets.
- STOP in SEND or GAP: go to IDLE, STB low, DONE unchanged (0). SENT_BYTES is held.
- STOP in IDLE or FINISH: no effect.
- CLEAR in any state: go to IDLE, SENT_BYTES=0, DONE=0, STB=0. START or STOP in the same cycle is ignored.
- Stopping or clearing while a byte is being offered is allowed.

## Timing
- Reset: DATA_OUT=0x00, DATA_OUT_STB=0, SENT_BYTES=0, BUSY=0, DONE=0, state IDLE. Reset asserted mid-transfer aborts immediately; no partial count.
- All outputs are registered.
- START sampled at edge n: STB=1, BUSY=1 and DATA_OUT=first byte are visible after edge n.
- Transfer at edge m: SENT_BYTES updates after edge m.
  - Back-to-back mode: the next DATA_OUT is valid after edge m, with STB still 1.
  - Final byte: STB=0, BUSY=0 and DONE=1 after edge m.
- GAP_CYCLES=G>0: STB low for edges m+1..m+G, high again after edge m+G.
- While STB=1 and ACK=0: DATA_OUT and STB hold indefinitely.
- STOP and ACK at the same edge: the transfer counts; STB=0 after that edge.
- CLEAR and ACK at the same edge: CLEAR wins; SENT_BYTES=0.
- Throughput with GAP_CYCLES=0: one byte per cycle when ACK is held high.

## Test plan
- Fixed mode: MODE=00, PATTERN=0x5A, BYTE_COUNT=4, ACK tied 1 -> four cycles of 0x5A with STB=1; then SENT_BYTES=4, DONE=1, STB=0.
- Incrementing with wrap: MODE=01, PATTERN=0xFE, BYTE_COUNT=3 -> bytes 0xFE, 0xFF, 0x00; DONE=1.
- PRBS-8 sequence and seed substitution:
  - Seed 0x01 -> 0x01, 0x02, 0x04, 0x08, 0x11, 0x23.
  - Seed 0x00 -> same sequence.
  - Continuous run -> 256th byte equals the 1st byte.
- Backpressure and gap: GAP_CYCLES=2, ACK low for 5 cycles then high -> DATA_OUT stable, STB held; then STB low for exactly 2 cycles between bytes.
- STOP mid-run: BYTE_COUNT=10, STOP with ACK at byte 3 -> SENT_BYTES=3, BUSY=0, DONE=0. A new START resets SENT_BYTES to 0.
- Priority and reset:
  - CLEAR with START -> remains IDLE, counters 0.
  - START while BUSY -> ignored.
  - OPB_RST asserted mid-run -> all outputs 0 with no clock edge required.
